pipe_skid_reg: RTL
==================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the datapath payload (operands, immediates, PCs, packed).
REQ-002 Parameter CTRL_W, default 8, width of the control payload (write enables, ALU op, result select, packed).
REQ-003 Parameter CLEAR_DATA, default 1, data-clear policy: 1 = data cleared on reset/flush; 0 = data held on reset/flush.
REQ-004 Parameter CNT_W, default 16, width of the stall counter.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous bubble insert; empties the stage.
REQ-008 in_valid  input  1  upstream presents a bundle.
REQ-009 in_ready  output  1  stage can accept a bundle this cycle.
REQ-010 in_ctrl  input  CTRL_W  upstream control payload.
REQ-011 in_data  input  DATA_W  upstream datapath payload.
REQ-012 out_valid  output  1  stage holds a bundle for downstream.
REQ-013 out_ready  input  1  downstream accepts the bundle this cycle.
REQ-014 out_ctrl  output  CTRL_W  control payload of the head bundle.
REQ-015 out_data  output  DATA_W  datapath payload of the head bundle.
REQ-016 stall_cnt  output  CNT_W  count of back-pressured cycles.

Function
REQ-017 The storage SHALL be two entries: main (drives outputs) and skid (overflow), each with a valid bit.
REQ-018 in_ready SHALL equal NOT skid_valid, taken directly from a register, with no combinational path from out_ready.
REQ-019 Accept SHALL occur on an edge where in_valid=1 and in_ready=1; pop SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-020 out_valid SHALL equal main_valid.
REQ-021 With main empty, an accepted bundle SHALL appear on out_* at the following edge (latency 1 cycle).
REQ-022 With main valid, a pop, and an accept on the same edge, main SHALL load the new bundle (throughput 1 per cycle).
REQ-023 With main valid, no pop, and an accept, the bundle SHALL load skid, and in_ready SHALL be 0 from the next cycle.
REQ-024 With skid valid and a pop, skid SHALL move into main, skid_valid SHALL clear, and in_ready SHALL return to 1 next cycle.
REQ-025 With main valid, a pop, and no accept or skid entry, main_valid SHALL clear.
REQ-026 Bundles SHALL leave in acceptance order; none SHALL be dropped or duplicated absent flush/reset.
REQ-027 out_ctrl SHALL read all-zero whenever out_valid=0, so a bubble never asserts any control bit.
REQ-028 When out_valid=0, out_data SHALL hold its last value, or read zero after a clear with CLEAR_DATA=1.
REQ-029 Flush SHALL clear main_valid, skid_valid, and both ctrl entries on the edge it is sampled; data SHALL be cleared only if CLEAR_DATA=1.
REQ-030 Any in_valid on a flush edge SHALL be discarded; in_ready SHALL be 1 on the cycle after a flush.
REQ-031 stall_cnt SHALL increment on each edge with out_valid=1 and out_ready=0, including flush edges, and SHALL saturate at 2^CNT_W-1.
REQ-032 stall_cnt SHALL be unaffected by flush.

Reset
REQ-033 Reset SHALL clear main_valid, skid_valid, both ctrl entries, and stall_cnt to 0; data SHALL be zeroed if CLEAR_DATA=1.
REQ-034 After reset, out_valid SHALL be 0, out_ctrl SHALL be 0, and in_ready SHALL be 1.
REQ-035 Reset SHALL take priority over flush and over any simultaneous accept or pop.

Verification
REQ-036 Stream: in_valid=1, out_ready=1, in_data=1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later, in_ready=1 throughout.
REQ-037 Back-pressure: out_ready=0, inputs A,B -> A in main, B in skid, in_ready=0; then out_ready=1 -> A, then B, in order; stall_cnt counts the held cycles.
REQ-038 Flush with both entries full and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the input is lost; stall_cnt unchanged by the flush itself.
REQ-039 Reset asserted mid-back-pressure together with flush -> all outputs at reset values, stall_cnt=0.
REQ-040 CNT_W=2 with out_ready held 0 for 6 cycles -> stall_cnt saturates at 3.
REQ-041 CLEAR_DATA=0, flush after out_data=0xDEADBEEF -> out_valid=0, out_ctrl=0, out_data=0xDEADBEEF.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Purpose: two-entry pipeline stage register (main + skid) carrying a control and a datapath payload.
// Latency: one cycle from accept to out_*; sustains one bundle per cycle while downstream drains.
// Backpressure: in_ready comes straight from a register (!skid_valid), so out_ready never reaches it combinationally.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   flush                 synchronous bubble insert; empties both entries, drops any same-edge input
//   in_valid/in_ready     upstream handshake; in_ctrl/in_data carry the bundle
//   out_valid/out_ready   downstream handshake; out_ctrl/out_data present the head (main) entry
//   stall_cnt             saturating count of edges with out_valid=1 and out_ready=0
module pipe_skid_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CTRL_W     = 8,
    parameter int unsigned CLEAR_DATA = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic pop;
    logic stall;

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    // Gate ctrl so a bubble can never assert a write enable or similar downstream,
    // regardless of what the main ctrl register still holds after a drain.
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    // Data is not gated: it keeps its last value while the stage is empty.
    assign out_data  = main_data;

    assign accept = in_valid & ~skid_valid;
    assign pop    = main_valid & out_ready;
    assign stall  = main_valid & ~out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
            stall_cnt  <= '0;
            if (CLEAR_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            // Counts on flush edges as well; flush never touches the counter.
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end

            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
                main_ctrl  <= '0;
                skid_ctrl  <= '0;
                if (CLEAR_DATA != 0) begin
                    main_data <= '0;
                    skid_data <= '0;
                end
            end else if (skid_valid && pop) begin
                // Skid is always older than anything upstream; no accept is possible here
                // because in_ready is low while skid is occupied.
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
                skid_ctrl  <= '0;
            end else if (accept && (!main_valid || pop)) begin
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else if (accept) begin
                // Main is held by downstream: park the new bundle in skid.
                skid_ctrl  <= in_ctrl;
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end else if (pop) begin
                main_valid <= 1'b0;
            end
        end
    end

endmodule
